// File: rtl/uart_core.sv
// uart_core: full-duplex UART with configurable frame format and a TX FIFO.
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   uart_rx / uart_tx  serial pins (uart_rx asynchronous, uart_tx idle high)
//   tx_data/valid/ready, tx_level, tx_busy   transmit side (valid/ready push)
//   rx_data/valid, rx_frame_err, rx_parity_err  receive side (1-cycle pulse, no backpressure)
module uart_core #(
    parameter int unsigned CLK_DIV       = 234,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY        = 0,
    parameter int unsigned STOP_BITS     = 1,
    parameter int unsigned TX_FIFO_DEPTH = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   uart_rx,
    output logic                                   uart_tx,
    input  logic [DATA_BITS-1:0]                   tx_data,
    input  logic                                   tx_valid,
    output logic                                   tx_ready,
    output logic [$clog2(TX_FIFO_DEPTH+1)-1:0]     tx_level,
    output logic                                   tx_busy,
    output logic [DATA_BITS-1:0]                   rx_data,
    output logic                                   rx_valid,
    output logic                                   rx_frame_err,
    output logic                                   rx_parity_err
);

    localparam int unsigned LW       = $clog2(TX_FIFO_DEPTH + 1);
    localparam int unsigned AW       = $clog2(TX_FIFO_DEPTH);
    localparam int unsigned STOP_LEN = STOP_BITS * CLK_DIV;
    localparam int unsigned TCW      = $clog2(STOP_LEN);
    localparam int unsigned RCW      = $clog2(CLK_DIV);
    localparam int unsigned BW       = $clog2(DATA_BITS);
    localparam int unsigned HALF     = CLK_DIV / 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // ---------------- TX FIFO + FSM ----------------
    logic [DATA_BITS-1:0] mem [TX_FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    state_t               tx_state;
    logic [TCW-1:0]       tx_cnt;
    logic [BW-1:0]        tx_idx;
    logic [DATA_BITS-1:0] tx_sh;
    logic                 tx_par;

    logic          push_c, pop_c, tx_bit_end_c, tx_stop_end_c, tx_idle_nxt_c, tx_line_c;
    logic [LW-1:0] level_nxt_c;

    // Handshake, pop timing and next occupancy
    always_comb begin
        push_c        = tx_valid && tx_ready;
        tx_bit_end_c  = (tx_cnt == TCW'(CLK_DIV - 1));
        tx_stop_end_c = (tx_state == S_STOP) && (tx_cnt == TCW'(STOP_LEN - 1));
        // Popping at the end of STOP gives back-to-back frames with no idle gap
        pop_c         = (tx_level != '0) && ((tx_state == S_IDLE) || tx_stop_end_c);
        level_nxt_c   = tx_level + LW'(push_c) - LW'(pop_c);
        tx_idle_nxt_c = !pop_c && ((tx_state == S_IDLE) || tx_stop_end_c);
    end

    // Line level for the current TX state; registered one cycle later into uart_tx
    always_comb begin
        tx_line_c = 1'b1;
        case (tx_state)
            S_START:  tx_line_c = 1'b0;
            S_DATA:   tx_line_c = tx_sh[0];
            S_PARITY: tx_line_c = tx_par;
            default:  tx_line_c = 1'b1;
        endcase
    end

    // FIFO storage, no reset needed
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    // TX control
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_sh    <= '0;
            tx_par   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            tx_level <= '0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b0;
            uart_tx  <= 1'b1;
        end else begin
            uart_tx  <= tx_line_c;
            tx_level <= level_nxt_c;
            tx_ready <= (level_nxt_c != LW'(TX_FIFO_DEPTH));
            tx_busy  <= !tx_idle_nxt_c || (level_nxt_c != '0);
            if (push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
                tx_sh  <= mem[rd_ptr];
                tx_par <= (PARITY == 1) ? ~(^mem[rd_ptr]) : (^mem[rd_ptr]);
            end
            case (tx_state)
                S_IDLE: begin
                    if (pop_c) begin
                        tx_state <= S_START;
                        tx_cnt   <= '0;
                    end
                end
                S_START: begin
                    if (tx_bit_end_c) begin
                        tx_cnt   <= '0;
                        tx_idx   <= '0;
                        tx_state <= S_DATA;
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                S_DATA: begin
                    if (tx_bit_end_c) begin
                        tx_cnt <= '0;
                        tx_sh  <= tx_sh >> 1;
                        if (tx_idx == BW'(DATA_BITS - 1)) begin
                            tx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            tx_idx <= tx_idx + BW'(1);
                        end
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                S_PARITY: begin
                    if (tx_bit_end_c) begin
                        tx_cnt   <= '0;
                        tx_state <= S_STOP;
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                S_STOP: begin
                    if (tx_stop_end_c) begin
                        tx_cnt   <= '0;
                        tx_state <= pop_c ? S_START : S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + TCW'(1);
                    end
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- RX synchroniser + FSM ----------------
    logic                 rx_meta, rx_sync;
    state_t               rx_state;
    logic [RCW-1:0]       rx_cnt;
    logic [BW-1:0]        rx_idx;
    logic [DATA_BITS-1:0] rx_sh;
    logic                 rx_par;
    logic                 rx_bit_end_c;

    assign rx_bit_end_c = (rx_cnt == RCW'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_sync       <= 1'b1;
            rx_state      <= S_IDLE;
            rx_cnt        <= '0;
            rx_idx        <= '0;
            rx_sh         <= '0;
            rx_par        <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
            rx_parity_err <= 1'b0;
        end else begin
            rx_meta  <= uart_rx;
            rx_sync  <= rx_meta;
            rx_valid <= 1'b0;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        rx_state <= S_START;
                        rx_cnt   <= '0;
                    end
                end
                S_START: begin
                    // Mid-start re-check; a high line here was only a glitch
                    if (rx_cnt == RCW'(HALF - 1)) begin
                        rx_cnt   <= '0;
                        rx_idx   <= '0;
                        rx_state <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                S_DATA: begin
                    if (rx_bit_end_c) begin
                        rx_cnt <= '0;
                        rx_sh  <= {rx_sync, rx_sh[DATA_BITS-1:1]};
                        if (rx_idx == BW'(DATA_BITS - 1)) begin
                            rx_state <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            rx_idx <= rx_idx + BW'(1);
                        end
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                S_PARITY: begin
                    if (rx_bit_end_c) begin
                        rx_cnt   <= '0;
                        rx_par   <= rx_sync;
                        rx_state <= S_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                S_STOP: begin
                    // Only the first stop bit is checked; back to IDLE at once
                    if (rx_bit_end_c) begin
                        rx_cnt        <= '0;
                        rx_valid      <= 1'b1;
                        rx_data       <= rx_sh;
                        rx_frame_err  <= !rx_sync;
                        rx_parity_err <= (PARITY == 0) ? 1'b0 :
                                         (PARITY == 1) ? ~(^rx_sh ^ rx_par) : (^rx_sh ^ rx_par);
                        rx_state      <= S_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt + RCW'(1);
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core, CLK_DIV=16 in all instances:
//   u0 8N1 depth 16 (TX timing, burst, RX errors/glitch, reset), u1 8E1 loopback,
//   u2 8O1 RX parity, u3 7-data 2-stop TX frame length.
module tb_uart_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // u0: 8N1
    logic [7:0] tx_data0, rx_data0;
    logic       tx_valid0, tx_ready0, tx_busy0, uart_tx0, rx_valid0, rx_ferr0, rx_perr0, ser0;
    logic [4:0] tx_level0;
    // u1: 8E1 loopback
    logic [7:0] tx_data1, rx_data1;
    logic       tx_valid1, tx_ready1, tx_busy1, uart_tx1, rx_valid1, rx_ferr1, rx_perr1;
    logic [4:0] tx_level1;
    // u2: 8O1 RX
    logic [7:0] tx_data2, rx_data2;
    logic       tx_valid2, tx_ready2, tx_busy2, uart_tx2, rx_valid2, rx_ferr2, rx_perr2, ser2;
    logic [4:0] tx_level2;
    // u3: 7 data, 2 stop, depth 4
    logic [6:0] tx_data3, rx_data3;
    logic       tx_valid3, tx_ready3, tx_busy3, uart_tx3, rx_valid3, rx_ferr3, rx_perr3;
    logic [2:0] tx_level3;

    uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .TX_FIFO_DEPTH(16)) u0 (
        .clk(clk), .rst(rst), .uart_rx(ser0), .uart_tx(uart_tx0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready0), .tx_level(tx_level0),
        .tx_busy(tx_busy0), .rx_data(rx_data0), .rx_valid(rx_valid0),
        .rx_frame_err(rx_ferr0), .rx_parity_err(rx_perr0));

    uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .TX_FIFO_DEPTH(16)) u1 (
        .clk(clk), .rst(rst), .uart_rx(uart_tx1), .uart_tx(uart_tx1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready1), .tx_level(tx_level1),
        .tx_busy(tx_busy1), .rx_data(rx_data1), .rx_valid(rx_valid1),
        .rx_frame_err(rx_ferr1), .rx_parity_err(rx_perr1));

    uart_core #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .TX_FIFO_DEPTH(16)) u2 (
        .clk(clk), .rst(rst), .uart_rx(ser2), .uart_tx(uart_tx2),
        .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_level(tx_level2),
        .tx_busy(tx_busy2), .rx_data(rx_data2), .rx_valid(rx_valid2),
        .rx_frame_err(rx_ferr2), .rx_parity_err(rx_perr2));

    uart_core #(.CLK_DIV(16), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .TX_FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .uart_rx(1'b1), .uart_tx(uart_tx3),
        .tx_data(tx_data3), .tx_valid(tx_valid3), .tx_ready(tx_ready3), .tx_level(tx_level3),
        .tx_busy(tx_busy3), .rx_data(rx_data3), .rx_valid(rx_valid3),
        .rx_frame_err(rx_ferr3), .rx_parity_err(rx_perr3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // RX pulse counters and loopback scoreboard
    int         rxcnt0 = 0, rxcnt2 = 0, rxcnt1 = 0;
    logic [7:0] lb_exp = 8'h00;
    always @(negedge clk) begin
        if (rx_valid0) rxcnt0++;
        if (rx_valid2) rxcnt2++;
        if (rx_valid1) begin
            rxcnt1++;
            check("lb_data", 32'(rx_data1), 32'(lb_exp));
            check("lb_ferr", 32'(rx_ferr1), 32'd0);
            check("lb_perr", 32'(rx_perr1), 32'd0);
            lb_exp = lb_exp + 8'd1;
        end
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) ser0 = v;
        else            ser2 = v;
    endtask

    // Drive one frame on ser0/ser2; par_mode 0 none, 1 odd, 2 even
    task automatic send_frame(input int which, input logic [7:0] d, input int par_mode,
                              input logic flip_par, input logic stop_v);
        logic p;
        p = 1'b0;
        set_line(which, 1'b0);
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_line(which, d[i]);
            p = p ^ d[i];
            ticks(16);
        end
        if (par_mode != 0) begin
            if (par_mode == 1) p = ~p;
            set_line(which, p ^ flip_par);
            ticks(16);
        end
        set_line(which, stop_v);
        ticks(16);
        set_line(which, 1'b1);
    endtask

    // Decode one 8N1 frame on uart_tx0, entered on the first cycle of its start bit
    task automatic frame_check(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        got = 8'h00;
        ticks(8);
        check({tag, "_start"}, 32'(uart_tx0), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ticks(16);
            got[i] = uart_tx0;
        end
        ticks(16);
        check({tag, "_stop"}, 32'(uart_tx0), 32'd1);
        check({tag, "_busy"}, 32'(tx_busy0), 32'd1);
        check(tag, 32'(got), 32'(exp));
        ticks(8);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int guard;
        rst = 1'b1;
        ser0 = 1'b1; ser2 = 1'b1;
        tx_valid0 = 1'b0; tx_valid1 = 1'b0; tx_valid2 = 1'b0; tx_valid3 = 1'b0;
        tx_data0 = 8'h00; tx_data1 = 8'h00; tx_data2 = 8'h00; tx_data3 = 7'h00;
        ticks(3);

        // Reset state
        check("rst_uart_tx", 32'(uart_tx0), 32'd1);
        check("rst_ready",   32'(tx_ready0), 32'd0);
        check("rst_level",   32'(tx_level0), 32'd0);
        check("rst_busy",    32'(tx_busy0), 32'd0);
        check("rst_rxvalid", 32'(rx_valid0), 32'd0);
        check("rst_rxdata",  32'(rx_data0), 32'd0);
        check("rst_ferr",    32'(rx_ferr0), 32'd0);
        check("rst_perr",    32'(rx_perr0), 32'd0);
        rst = 1'b0;
        ticks(1);
        check("rst_ready_after", 32'(tx_ready0), 32'd1);

        // 8N1 single byte: fall two edges after accept
        tx_data0 = 8'hA5; tx_valid0 = 1'b1;
        ticks(1);
        tx_valid0 = 1'b0;
        check("t1_e0_high", 32'(uart_tx0), 32'd1);
        ticks(1);
        check("t1_e1_high", 32'(uart_tx0), 32'd1);
        ticks(1);
        check("t1_fall", 32'(uart_tx0), 32'd0);
        frame_check("t1", 8'hA5);
        check("t1_idle_line", 32'(uart_tx0), 32'd1);
        check("t1_idle_busy", 32'(tx_busy0), 32'd0);

        // Burst: one byte in flight, then fill FIFO; 17th byte refused
        tx_data0 = 8'h11; tx_valid0 = 1'b1;
        ticks(1);
        tx_valid0 = 1'b0;
        ticks(2);
        check("burst_lvl0", 32'(tx_level0), 32'd0);
        tx_valid0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data0 = 8'h20 + 8'(i);
            ticks(1);
        end
        check("burst_ready_full", 32'(tx_ready0), 32'd0);
        check("burst_level_full", 32'(tx_level0), 32'd16);
        tx_data0 = 8'hEE;
        ticks(1);
        tx_valid0 = 1'b0;
        check("burst_refused_level", 32'(tx_level0), 32'd16);
        ticks(143);
        for (int i = 0; i < 16; i++) begin
            frame_check($sformatf("burst%0d", i), 8'h20 + 8'(i));
        end
        check("burst_end_busy", 32'(tx_busy0), 32'd0);
        check("burst_end_line", 32'(uart_tx0), 32'd1);

        // Frame error: stop bit low, data still captured
        base = rxcnt0;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
        ticks(30);
        check("ferr_count", 32'(rxcnt0 - base), 32'd1);
        check("ferr_data",  32'(rx_data0), 32'h3C);
        check("ferr_flag",  32'(rx_ferr0), 32'd1);
        check("ferr_perr",  32'(rx_perr0), 32'd0);

        // Glitch: 5-cycle low pulse, then a good frame
        base = rxcnt0;
        ser0 = 1'b0;
        ticks(5);
        ser0 = 1'b1;
        ticks(30);
        check("glitch_no_valid", 32'(rxcnt0 - base), 32'd0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1);
        ticks(20);
        check("glitch_next_count", 32'(rxcnt0 - base), 32'd1);
        check("glitch_next_data",  32'(rx_data0), 32'h5A);
        check("glitch_next_ferr",  32'(rx_ferr0), 32'd0);

        // 8O1 parity: wrong then correct
        base = rxcnt2;
        send_frame(2, 8'hA5, 1, 1'b1, 1'b1);
        ticks(20);
        check("perr_count", 32'(rxcnt2 - base), 32'd1);
        check("perr_flag",  32'(rx_perr2), 32'd1);
        check("perr_ferr",  32'(rx_ferr2), 32'd0);
        check("perr_data",  32'(rx_data2), 32'hA5);
        send_frame(2, 8'h07, 1, 1'b0, 1'b1);
        ticks(20);
        check("pok_count", 32'(rxcnt2 - base), 32'd2);
        check("pok_flag",  32'(rx_perr2), 32'd0);
        check("pok_data",  32'(rx_data2), 32'h07);

        // 7 data, 2 stop: frame is 160 cycles, next frame follows directly
        tx_data3 = 7'h7F; tx_valid3 = 1'b1;
        ticks(1);
        tx_data3 = 7'h00;
        ticks(1);
        tx_valid3 = 1'b0;
        check("d7_level", 32'(tx_level3), 32'd1);
        check("d7_e1_high", 32'(uart_tx3), 32'd1);
        ticks(1);
        check("d7_fall", 32'(uart_tx3), 32'd0);
        ticks(16);
        check("d7_bit0", 32'(uart_tx3), 32'd1);
        ticks(143);
        check("d7_stop_end", 32'(uart_tx3), 32'd1);
        ticks(1);
        check("d7_next_start", 32'(uart_tx3), 32'd0);
        ticks(170);

        // 8E1 loopback of 0x00..0xFF
        for (int i = 0; i < 256; i++) begin
            tx_data1 = 8'(i);
            tx_valid1 = 1'b1;
            guard = 0;
            while (!tx_ready1 && guard < 1000) begin
                ticks(1);
                guard++;
            end
            ticks(1);
        end
        tx_valid1 = 1'b0;
        guard = 0;
        while (rxcnt1 < 256 && guard < 60000) begin
            ticks(1);
            guard++;
        end
        check("lb_count", 32'(rxcnt1), 32'd256);

        // Reset mid-frame at bit 3 with four bytes queued
        tx_data0 = 8'h00; tx_valid0 = 1'b1;
        ticks(5);
        tx_valid0 = 1'b0;
        check("rst_mid_level", 32'(tx_level0), 32'd4);
        ticks(70);
        check("rst_mid_line", 32'(uart_tx0), 32'd0);
        rst = 1'b1;
        ticks(1);
        check("rst_mid_tx_high", 32'(uart_tx0), 32'd1);
        check("rst_mid_lvl0",    32'(tx_level0), 32'd0);
        check("rst_mid_ready0",  32'(tx_ready0), 32'd0);
        check("rst_mid_busy0",   32'(tx_busy0), 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(1);
        check("rst_mid_ready1", 32'(tx_ready0), 32'd1);
        ticks(20);
        check("rst_mid_quiet", 32'(uart_tx0), 32'd1);
        check("rst_mid_idle",  32'(tx_busy0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
